// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared types and width helpers for the
// two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam int DEF_ADR_W      = 32;
  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_MAX_BURST  = 64;

  function automatic int data_w(input int bytes);
    return 8 * bytes;
  endfunction

  // MAX_BURST of 0 still needs a 1-bit counter to keep widths legal
  function automatic int tcnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/wshb_sdram_arbiter.sv
// wshb_sdram_arbiter: round-robin, bounded-tenure sharing of
// the SDRAM Wishbone slave between video reader and generic master.
module wshb_sdram_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int ADR_W      = DEF_ADR_W,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  localparam int DW        = data_w(DATA_BYTES)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,

  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADR_W-1:0]      m0_adr,
  input  logic [DW-1:0]         m0_dat_ms,
  input  logic [DATA_BYTES-1:0] m0_sel,
  input  logic [2:0]            m0_cti,
  input  logic [1:0]            m0_bte,
  output logic [DW-1:0]         m0_dat_sm,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic                  m0_rty,

  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADR_W-1:0]      m1_adr,
  input  logic [DW-1:0]         m1_dat_ms,
  input  logic [DATA_BYTES-1:0] m1_sel,
  input  logic [2:0]            m1_cti,
  input  logic [1:0]            m1_bte,
  output logic [DW-1:0]         m1_dat_sm,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  m1_rty,

  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADR_W-1:0]      s_adr,
  output logic [DW-1:0]         s_dat_ms,
  output logic [DATA_BYTES-1:0] s_sel,
  output logic [2:0]            s_cti,
  output logic [1:0]            s_bte,
  input  logic [DW-1:0]         s_dat_sm,
  input  logic                  s_ack,
  input  logic                  s_err,
  input  logic                  s_rty,

  output logic [1:0]            grant
);

  localparam int TW = tcnt_w(MAX_BURST);
  localparam logic [TW-1:0] T_LAST =
    TW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_BURST);

  arb_state_t    state;
  arb_state_t    other;
  logic          last;
  logic [TW-1:0] tcnt;
  logic          own_cyc;
  logic          oth_cyc;
  logic          term;
  logic          preempt;
  logic          g0;
  logic          g1;

  assign g0    = (state == GNT0);
  assign g1    = (state == GNT1);
  assign grant = {g1, g0};

  always_comb begin
    own_cyc = 1'b0;
    oth_cyc = 1'b0;
    other   = IDLE;
    unique case (1'b1)
      g0: begin
        own_cyc = m0_cyc;
        oth_cyc = m1_cyc;
        other   = GNT1;
      end
      g1: begin
        own_cyc = m1_cyc;
        oth_cyc = m0_cyc;
        other   = GNT0;
      end
      default: ;
    endcase
  end

  // a termination only counts while the owner still holds cyc
  assign term    = own_cyc & (s_ack | s_err | s_rty);
  assign preempt = (MAX_BURST > 0) && term &&
                   (tcnt == T_LAST) && oth_cyc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (m0_cyc && (!m1_cyc || last))
            state <= GNT0;
          else if (m1_cyc)
            state <= GNT1;
        end
        default: begin
          if (!own_cyc || preempt) begin
            last  <= g1;
            tcnt  <= '0;
            state <= oth_cyc ? other : IDLE;
          end else if (term && tcnt != T_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_ms  = '0;
    s_sel     = '0;
    s_cti     = '0;
    s_bte     = '0;
    m0_dat_sm = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rty    = 1'b0;
    m1_dat_sm = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rty    = 1'b0;
    unique case (1'b1)
      g0: begin
        s_cyc     = m0_cyc;
        s_stb     = m0_stb;
        s_we      = m0_we;
        s_adr     = m0_adr;
        s_dat_ms  = m0_dat_ms;
        s_sel     = m0_sel;
        s_cti     = m0_cti;
        s_bte     = m0_bte;
        m0_dat_sm = s_dat_sm;
        m0_ack    = s_ack;
        m0_err    = s_err;
        m0_rty    = s_rty;
      end
      g1: begin
        s_cyc     = m1_cyc;
        s_stb     = m1_stb;
        s_we      = m1_we;
        s_adr     = m1_adr;
        s_dat_ms  = m1_dat_ms;
        s_sel     = m1_sel;
        s_cti     = m1_cti;
        s_bte     = m1_bte;
        m1_dat_sm = s_dat_sm;
        m1_ack    = s_ack;
        m1_err    = s_err;
        m1_rty    = s_rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// tb_wshb_sdram_arbiter: directed bench, instance 0 with
// MAX_BURST=4 and instance 1 with MAX_BURST=0.
module tb_wshb_sdram_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        mcyc[2][2];
  logic        mstb[2][2];
  logic        mwe[2][2];
  logic [31:0] madr[2][2];
  logic [31:0] mdms[2][2];
  logic [31:0] mdsm[2][2];
  logic [3:0]  msel[2][2];
  logic [2:0]  mcti[2][2];
  logic [1:0]  mbte[2][2];
  logic        mack[2][2];
  logic        merr[2][2];
  logic        mrty[2][2];

  logic        scyc[2];
  logic        sstb[2];
  logic        swe[2];
  logic [31:0] sadr[2];
  logic [31:0] sdms[2];
  logic [31:0] sdsm[2];
  logic [3:0]  ssel[2];
  logic [2:0]  scti[2];
  logic [1:0]  sbte[2];
  logic        sack[2];
  logic        serr[2];
  logic        srty[2];
  logic [1:0]  grant[2];

  logic        ack_en[2];
  logic        err_en[2];

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    assign sack[g] = scyc[g] & sstb[g] & ack_en[g] & ~err_en[g];
    assign serr[g] = scyc[g] & sstb[g] & err_en[g];
    assign srty[g] = 1'b0;
    assign sdsm[g] = sadr[g] ^ KEY;

    wshb_sdram_arbiter #(
      .ADR_W(32),
      .DATA_BYTES(4),
      .MAX_BURST(g == 0 ? 4 : 0)
    ) u_dut (
      .sys_clk(clk),
      .sys_rst_n(rst_n),
      .m0_cyc(mcyc[g][0]),
      .m0_stb(mstb[g][0]),
      .m0_we(mwe[g][0]),
      .m0_adr(madr[g][0]),
      .m0_dat_ms(mdms[g][0]),
      .m0_sel(msel[g][0]),
      .m0_cti(mcti[g][0]),
      .m0_bte(mbte[g][0]),
      .m0_dat_sm(mdsm[g][0]),
      .m0_ack(mack[g][0]),
      .m0_err(merr[g][0]),
      .m0_rty(mrty[g][0]),
      .m1_cyc(mcyc[g][1]),
      .m1_stb(mstb[g][1]),
      .m1_we(mwe[g][1]),
      .m1_adr(madr[g][1]),
      .m1_dat_ms(mdms[g][1]),
      .m1_sel(msel[g][1]),
      .m1_cti(mcti[g][1]),
      .m1_bte(mbte[g][1]),
      .m1_dat_sm(mdsm[g][1]),
      .m1_ack(mack[g][1]),
      .m1_err(merr[g][1]),
      .m1_rty(mrty[g][1]),
      .s_cyc(scyc[g]),
      .s_stb(sstb[g]),
      .s_we(swe[g]),
      .s_adr(sadr[g]),
      .s_dat_ms(sdms[g]),
      .s_sel(ssel[g]),
      .s_cti(scti[g]),
      .s_bte(sbte[g]),
      .s_dat_sm(sdsm[g]),
      .s_ack(sack[g]),
      .s_err(serr[g]),
      .s_rty(srty[g]),
      .grant(grant[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      ack_en[d] = 1'b1;
      err_en[d] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mcyc[d][i] = 1'b0;
        mstb[d][i] = 1'b0;
        mwe[d][i]  = 1'b0;
        madr[d][i] = '0;
        mdms[d][i] = '0;
        msel[d][i] = 4'hF;
        mcti[d][i] = 3'b000;
        mbte[d][i] = 2'b00;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input int d, input int m, input logic on,
                       input logic we, input logic [31:0] adr,
                       input logic [31:0] dat);
    mcyc[d][m] = on;
    mstb[d][m] = on;
    mwe[d][m]  = we;
    madr[d][m] = adr;
    mdms[d][m] = dat;
  endtask

  // m1 writes nw words; m0 reads 2 words once m1 owns the bus
  task automatic burst(input int d, input int nw, input int mb);
    int n1 = 0;
    int n0 = 0;
    int bad = 0;
    bit m0_on = 0;
    bit pre_chk = 0;
    bit done = 0;
    bit a0;
    bit a1;
    logic [1:0] g;
    q0.delete();
    q1.delete();
    drive(d, 1, 1'b1, 1'b1, 32'h1000, 32'hD000);
    q1.push_back(32'h1000);
    for (int c = 0; c < 400 && !done; c++) begin
      settle();
      g  = grant[d];
      a0 = mack[d][0];
      a1 = mack[d][1];
      if (pre_chk) begin
        chk("pre_grant", 32'(g), 32'h1);
        chk("pre_m1_ack", 32'(a1), 32'h0);
        pre_chk = 0;
      end
      if (mb == 0 && m0_on && n1 < nw && (g != 2'b10 || a0))
        bad++;
      if (a1) begin
        chk("m1_adr", sadr[d], q1.pop_front());
        chk("m1_we", 32'(swe[d]), 32'h1);
        n1++;
        if (mb > 0 && n1 == mb) pre_chk = 1;
      end
      if (a0) begin
        chk("m0_dat", mdsm[d][0], q0.pop_front());
        n0++;
      end
      done = (n1 == nw) && (n0 == 2);
      tick();
      if (!m0_on && g == 2'b10) begin
        m0_on = 1;
        drive(d, 0, 1'b1, 1'b0, 32'h2000, 32'h0);
        q0.push_back(32'h2000 ^ KEY);
      end
      if (a1) begin
        if (n1 < nw) begin
          madr[d][1] = 32'h1000 + 32'(4 * n1);
          mdms[d][1] = 32'hD000 + 32'(n1);
          q1.push_back(madr[d][1]);
        end else begin
          drive(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
      if (a0) begin
        if (n0 < 2) begin
          madr[d][0] = 32'h2000 + 32'(4 * n0);
          q0.push_back(madr[d][0] ^ KEY);
        end else begin
          drive(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    chk("burst_done", 32'(done), 32'h1);
    if (mb == 0) chk("nopre_bad", 32'(bad), 32'h0);
    tick();
    settle();
    chk("burst_idle", 32'(grant[d]), 32'h0);
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", 32'(grant[d]), 32'h0);
      chk("rst_scyc", 32'(scyc[d]), 32'h0);
      chk("rst_m0_ack", 32'(mack[d][0]), 32'h0);
    end
    tick();
    rst_n = 1'b1;

    // single requester, grant latency, pass-through
    drive(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    chk("t1_lat_scyc", 32'(scyc[0]), 32'h0);
    chk("t1_lat_grant", 32'(grant[0]), 32'h0);
    tick();
    settle();
    chk("t1_grant", 32'(grant[0]), 32'h1);
    chk("t1_scyc", 32'(scyc[0]), 32'h1);
    chk("t1_sadr", sadr[0], 32'h100);
    chk("t1_m0_ack", 32'(mack[0][0]), 32'h1);
    chk("t1_m1_ack", 32'(mack[0][1]), 32'h0);
    chk("t1_m0_dat", mdsm[0][0], 32'h100 ^ KEY);
    chk("t1_m1_dat", mdsm[0][1], 32'h0);
    tick();
    ack_en[0] = 1'b0;
    settle();
    chk("t1_m0_noack", 32'(mack[0][0]), 32'h0);
    tick();
    ack_en[0] = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t1_drop_scyc", 32'(scyc[0]), 32'h0);
    tick();
    settle();
    chk("t1_idle", 32'(grant[0]), 32'h0);

    // contention from idle and direct handover
    do_reset();
    drive(0, 0, 1'b1, 1'b0, 32'h200, 32'h0);
    drive(0, 1, 1'b1, 1'b1, 32'h300, 32'hCAFE);
    tick();
    settle();
    chk("t2_grant0", 32'(grant[0]), 32'h1);
    chk("t2_sadr0", sadr[0], 32'h200);
    chk("t2_m1_ack", 32'(mack[0][1]), 32'h0);
    tick();
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t2_hold", 32'(grant[0]), 32'h1);
    tick();
    settle();
    chk("t2_grant1", 32'(grant[0]), 32'h2);
    chk("t2_sadr1", sadr[0], 32'h300);
    chk("t2_swe1", 32'(swe[0]), 32'h1);
    chk("t2_sdms1", sdms[0], 32'hCAFE);
    chk("t2_m1_ack1", 32'(mack[0][1]), 32'h1);
    chk("t2_m0_dat", mdsm[0][0], 32'h0);
    tick();
    drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    chk("t2_idle", 32'(grant[0]), 32'h0);
    drive(0, 0, 1'b1, 1'b0, 32'h210, 32'h0);
    drive(0, 1, 1'b1, 1'b1, 32'h310, 32'h0);
    tick();
    settle();
    chk("t2_rr_m0", 32'(grant[0]), 32'h1);
    tick();
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);

    // bounded tenure, then no preemption when disabled
    do_reset();
    burst(0, 10, 4);
    do_reset();
    burst(1, 100, 0);

    // err is passed through and counts toward tenure
    do_reset();
    drive(0, 0, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    settle();
    chk("t5_ack1", 32'(mack[0][0]), 32'h1);
    tick();
    drive(0, 1, 1'b1, 1'b1, 32'h500, 32'h0);
    tick();
    tick();
    err_en[0] = 1'b1;
    settle();
    chk("t5_m0_err", 32'(merr[0][0]), 32'h1);
    chk("t5_m0_ack", 32'(mack[0][0]), 32'h0);
    chk("t5_m1_err", 32'(merr[0][1]), 32'h0);
    tick();
    err_en[0] = 1'b0;
    settle();
    chk("t5_err_counted", 32'(grant[0]), 32'h2);
    tick();
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset in the middle of an m1 tenure
    do_reset();
    drive(0, 1, 1'b1, 1'b1, 32'h600, 32'h0);
    tick();
    settle();
    chk("t6_grant1", 32'(grant[0]), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_scyc", 32'(scyc[0]), 32'h0);
    chk("t6_rst_grant", 32'(grant[0]), 32'h0);
    chk("t6_rst_m1_ack", 32'(mack[0][1]), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    settle();
    chk("t6_post_m0", 32'(grant[0]), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wshb_sdram_arbiter.md
Name: wshb_sdram_arbiter

Overview:
- Shares the single SDRAM Wishbone slave port of the hardware support block between two Wishbone masters.
- Master 0 is the video stream reader; master 1 is the generic master (frame writer / CPU bridge).
- Arbitration is round-robin with bounded tenure, so video reads cannot be starved by long write bursts.
- Sits in Top between the masters and the SDRAM slave interface, all on sys_clk.

Parameters:
- ADR_W, 32, address width.
- DATA_BYTES, 4, data bus width in bytes (data width = 8*DATA_BYTES).
- MAX_BURST, 64, terminations allowed per tenure before forced handover when the other master waits; 0 disables preemption.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- mN_cyc, mN_stb, mN_we  in  1 each  master N (N=0,1) cycle, strobe, write enable.
- mN_adr  in  ADR_W  master N address.
- mN_dat_ms  in  8*DATA_BYTES  master N write data.
- mN_sel  in  DATA_BYTES  master N byte selects.
- mN_cti  in  3  master N cycle type.
- mN_bte  in  2  master N burst type.
- mN_dat_sm  out  8*DATA_BYTES  read data to master N.
- mN_ack, mN_err, mN_rty  out  1 each  terminations to master N.
- s_cyc, s_stb, s_we  out  1 each  to SDRAM slave.
- s_adr, s_dat_ms, s_sel, s_cti, s_bte  out  same widths as master side  to SDRAM slave.
- s_dat_sm  in  8*DATA_BYTES  read data from slave.
- s_ack, s_err, s_rty  in  1 each  terminations from slave.
- grant  out  2  one-hot current owner; 00 = idle.

Behaviour:
- FSM states IDLE, GNT0, GNT1. The state register, last-served pointer `last` and tenure counter `tcnt` are the only sequential state.
- Reset (async, sys_rst_n=0): state=IDLE, last=1, tcnt=0, grant=00.
  - All s_* and mN_ack/err/rty outputs are 0 immediately, combinational from state.
  - Reset mid-transfer aborts the transfer with no termination to either master.
- IDLE:
  - Only one mN_cyc=1: go to GNTN.
  - Both high: grant the master with index != last. After reset, m0 wins.
  - Neither high: stay.
- Grant latency: cyc sampled high at edge k; s_cyc is high in cycle k+1. There is no combinational cyc-to-s_cyc path through IDLE.
- GNTN output muxing (combinational):
  - s_cyc=mN_cyc, s_stb=mN_stb.
  - s_we/adr/dat_ms/sel/cti/bte = master N values.
  - mN_dat_sm=s_dat_sm; mN_ack/err/rty = s_ack/err/rty.
- Non-granted master: ack/err/rty forced 0, dat_sm driven 0. Its cyc/stb are ignored; it simply waits.
- IDLE output values: s_cyc=s_stb=0; other s_* driven 0.
- Termination event: term = s_ack|s_err|s_rty while in GNTN.
  - tcnt increments on each term, saturating at MAX_BURST.
  - tcnt clears on every grant change.
- Release:
  - In GNTN, mN_cyc=0 sampled: if the other master's cyc=1, go directly to GNT(other). Otherwise go to IDLE.
  - On any exit from GNTN, last=N.
- Preemption (MAX_BURST>0):
  - Condition: in GNTN with term at this edge, tcnt==MAX_BURST-1, and the other cyc=1.
  - Action: switch to GNT(other) at that edge; last=N.
  - Preempted master N keeps cyc high without acks; it is regranted by the normal round-robin rules.
  - s_stb is never asserted for the old owner after the preempting edge.
- Simultaneous events:
  - Release and preemption on the same edge resolve identically (go to other).
  - term while the owner's cyc=0 is ignored.
- err and rty are passed through unchanged and count as terminations.

Decomposition:
- Package wshb_arb_pkg: state enum (IDLE, GNT0, GNT1), width localparams (DATA_W=8*DATA_BYTES, TCNT_W=$clog2(MAX_BURST+1)).
- No sub-module. FSM, tenure counter and output mux live in one file. The output mux may be a function in the package.

Test Plan:
- Reset release, m0 only: m0_cyc=stb=1, adr=0x100. s_cyc high one cycle after sampling, s_adr=0x100, grant=01, m0_ack mirrors s_ack, m1_ack=0.
- Both request from IDLE after reset: m0 granted first. When m0 drops cyc while m1_cyc=1, grant goes 01→10 with no IDLE cycle. The next contention from IDLE grants m0 (last=1).
- Preemption, MAX_BURST=4: m1 bursts 10 words while m0 requests. After the 4th m1 ack, grant=01. m1 sees no ack until m0 releases, then resumes at word 5 with the correct address.
- MAX_BURST=0: m1 bursts 100 words with m0 waiting. No handover until m1_cyc=0.
- s_err on m0 read: m0_err=1 in the same cycle, m1_err=0, tcnt counts it.
- Reset asserted mid-burst (grant=10): s_cyc=0 and grant=00 combinationally. After release, simultaneous requests grant m0.
